// File: rtl/ena_scheduler_pkg.sv
// Shared definitions for the enable scheduler: FSM state type, counter width
// and Galois LFSR tap masks.
package sched_pkg;

   localparam int unsigned STEPS_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_FIRE   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Right-shifting Galois tap masks for maximal-length polynomials.
   function automatic logic [63:0] lfsr_taps(input int unsigned w);
      logic [63:0] taps;
      case (w)
         3:       taps = 64'h6;
         4:       taps = 64'hC;
         5:       taps = 64'h14;
         6:       taps = 64'h30;
         7:       taps = 64'h60;
         8:       taps = 64'hB8;
         10:      taps = 64'h240;
         12:      taps = 64'hE08;
         16:      taps = 64'hB400;
         24:      taps = 64'hE10000;
         32:      taps = 64'hA3000000;
         default: taps = 64'hB400;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/ena_scheduler_rr_pick.sv
// Wrap-around first-one finder: lowest set bit of req at or above base,
// wrapping past the top index back to 0.
module rr_pick #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan N positions starting at base; the first hit wins.
   always_comb begin
      int unsigned pos;
      idx   = '0;
      valid = 1'b0;
      pos   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = 32'(base) + i;
         if (pos >= N) pos = pos - N;
         if (!valid && req[pos[IW-1:0]]) begin
            valid = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/ena_scheduler.sv
// Enable scheduler: repeatedly picks one excited signal and pulses its enable
// for a single cycle, in round-robin or LFSR-driven pseudo-random order,
// until the firing budget is spent or nothing is excited.
module ena_scheduler
   import sched_pkg::*;
#(
   parameter int unsigned ENA_BITS = 8,
   parameter int unsigned LFSR_W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [LFSR_W-1:0]   seed,
   input  logic [STEPS_W-1:0]  max_steps,
   input  logic                hold,
   input  logic [ENA_BITS-1:0] excited,
   output logic [ENA_BITS-1:0] ena,
   output logic                busy,
   output logic                done,
   output logic                deadlock,
   output logic [STEPS_W-1:0]  steps
);

   localparam int unsigned        IW       = (ENA_BITS > 1) ? $clog2(ENA_BITS) : 1;
   localparam logic [IW-1:0]      LAST_IDX = IW'(ENA_BITS - 1);
   localparam logic [LFSR_W-1:0]  TAPS     = LFSR_W'(lfsr_taps(LFSR_W));

   state_e               state_q, state_d;
   logic [ENA_BITS-1:0]  ena_q, ena_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
   logic                 mode_q, mode_d;
   logic [STEPS_W-1:0]   max_q, max_d;
   logic [STEPS_W-1:0]   steps_q, steps_d;
   logic                 deadlock_q, deadlock_d;
   logic                 done_q, done_d;

   logic [LFSR_W-1:0]    lfsr_next;
   logic [STEPS_W-1:0]   steps_inc;
   logic [IW-1:0]        base;
   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;

   assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
   assign steps_inc = steps_q + STEPS_W'(1);
   assign base      = mode_q ? IW'(lfsr_q % LFSR_W'(ENA_BITS)) : ptr_q;

   rr_pick #(
      .N  (ENA_BITS),
      .IW (IW)
   ) u_pick (
      .req   (excited),
      .base  (base),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Next-state and datapath updates for the IDLE/SELECT/FIRE/DONE sequence.
   always_comb begin
      state_d    = state_q;
      ena_d      = '0;
      ptr_d      = ptr_q;
      lfsr_d     = lfsr_q;
      mode_d     = mode_q;
      max_d      = max_q;
      steps_d    = steps_q;
      deadlock_d = deadlock_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_SELECT;
               mode_d     = mode;
               max_d      = max_steps;
               lfsr_d     = (seed == '0) ? LFSR_W'(1) : seed;
               steps_d    = '0;
               deadlock_d = 1'b0;
               ptr_d      = '0;
            end
         end
         ST_SELECT: begin
            if (!hold) begin
               if (!pick_valid) begin
                  state_d    = ST_DONE;
                  deadlock_d = 1'b1;
               end else begin
                  state_d = ST_FIRE;
                  ena_d   = ENA_BITS'(1) << pick_idx;
                  if (mode_q) lfsr_d = lfsr_next;
                  else        ptr_d  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
               end
            end
         end
         ST_FIRE: begin
            steps_d = steps_inc;
            if (max_q != '0 && steps_inc == max_q) state_d = ST_DONE;
            else                                   state_d = ST_SELECT;
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ena_q      <= '0;
         ptr_q      <= '0;
         lfsr_q     <= LFSR_W'(1);
         mode_q     <= 1'b0;
         max_q      <= '0;
         steps_q    <= '0;
         deadlock_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ena_q      <= ena_d;
         ptr_q      <= ptr_d;
         lfsr_q     <= lfsr_d;
         mode_q     <= mode_d;
         max_q      <= max_d;
         steps_q    <= steps_d;
         deadlock_q <= deadlock_d;
         done_q     <= done_d;
      end
   end

   assign ena      = ena_q;
   assign busy     = (state_q == ST_SELECT) || (state_q == ST_FIRE);
   assign done     = done_q;
   assign deadlock = deadlock_q;
   assign steps    = steps_q;

endmodule

// File: tb/tb_ena_scheduler.sv
// Bench for ena_scheduler: a stimulus process walks each run and pushes the
// expected enables and end-of-run results; a monitor pops and compares them.
module tb_ena_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned LW = 16;

   logic          clk = 1'b0;
   logic          reset, start, mode, hold;
   logic [LW-1:0] seed;
   logic [15:0]   max_steps;
   logic [N-1:0]  excited;
   logic [N-1:0]  ena;
   logic          busy, done, deadlock;
   logic [15:0]   steps;

   always #5 clk = ~clk;

   ena_scheduler #(
      .ENA_BITS (N),
      .LFSR_W   (LW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .seed      (seed),
      .max_steps (max_steps),
      .hold      (hold),
      .excited   (excited),
      .ena       (ena),
      .busy      (busy),
      .done      (done),
      .deadlock  (deadlock),
      .steps     (steps)
   );

   typedef struct {
      logic [15:0] steps;
      logic        dl;
   } end_t;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   logic [N-1:0] exp_ena_q[$];
   end_t         exp_end_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: first excited index at or above b, wrapping modulo N.
   function automatic int pick(input logic [N-1:0] e, input int b);
      for (int i = 0; i < int'(N); i++) begin
         int j;
         j = (b + i) % int'(N);
         if (e[j]) return j;
      end
      return -1;
   endfunction

   // Reference: x^16+x^14+x^13+x^11+1 Galois step.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Monitor: compares each visible enable and each done pulse with the queues.
   logic [N-1:0] prev_exc = '0;
   logic [N-1:0] prev_ena = '0;
   logic [N-1:0] mon_e;
   end_t         mon_end;
   always @(negedge clk) begin
      if (ena !== '0) begin
         chk("ena_onehot", 32'($onehot(ena)), 32'd1);
         chk("ena_within_excited", 32'(ena & ~prev_exc), 32'd0);
         chk("ena_back_to_back", 32'(prev_ena), 32'd0);
         if (exp_ena_q.size() == 0) begin
            chk("ena_unexpected", 32'(ena), 32'd0);
         end else begin
            mon_e = exp_ena_q.pop_front();
            chk("ena_value", 32'(ena), 32'(mon_e));
         end
      end
      if (done === 1'b1) begin
         if (exp_end_q.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'd0);
         end else begin
            mon_end = exp_end_q.pop_front();
            chk("done_steps", 32'(steps), 32'(mon_end.steps));
            chk("done_deadlock", 32'(deadlock), 32'(mon_end.dl));
         end
      end
      prev_exc = excited;
      prev_ena = ena;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One run. dl_after: drive excited=0 at the SELECT following that many
   // firings; hold_at: 5-cycle hold burst after that many firings; reset_at:
   // reset during the FIRE cycle of that firing (1-based). -1 disables each.
   task automatic run(input bit m, input logic [15:0] sd, input logic [15:0] mx,
                      input bit use_fixed, input logic [N-1:0] fixed,
                      input int dl_after, input int hold_at, input int reset_at,
                      input bit rand_hold);
      int           p, k, b, fired, burst;
      logic [15:0]  lf, st;
      logic [N-1:0] ex;
      bit           h;
      p = 0; lf = (sd == 16'd0) ? 16'd1 : sd; st = 16'd0; fired = 0; burst = 0;
      start = 1'b1; mode = m; seed = sd; max_steps = mx; hold = 1'b0;
      excited = N'($urandom);
      step();
      start = 1'b0; mode = 1'($urandom); seed = 16'($urandom); max_steps = 16'($urandom);
      forever begin
         chk("busy_select", 32'(busy), 32'd1);
         chk("steps_running", 32'(steps), 32'(st));
         h = 1'b0;
         if (hold_at == fired && burst < 5) begin
            h = 1'b1;
            burst++;
         end else if (rand_hold && $urandom_range(0, 4) == 0) begin
            h = 1'b1;
         end
         hold = h;
         if (h)                     excited = N'($urandom);
         else if (use_fixed)        excited = fixed;
         else if (dl_after == fired) excited = '0;
         else begin
            do ex = N'($urandom); while (ex == '0);
            excited = ex;
         end
         step();
         if (h) begin
            chk("hold_ena_zero", 32'(ena), 32'd0);
            continue;
         end
         if (excited == '0) begin
            exp_end_q.push_back(end_t'{steps: st, dl: 1'b1});
            break;
         end
         b = m ? (int'(lf) % int'(N)) : p;
         k = pick(excited, b);
         exp_ena_q.push_back(N'(1) << k);
         if (m) lf = lfsr_step(lf);
         else   p  = (k + 1) % int'(N);
         fired++;
         chk("busy_fire", 32'(busy), 32'd1);
         hold = 1'($urandom);
         excited = N'($urandom);
         start = ($urandom_range(0, 3) == 0);
         mode = 1'($urandom); seed = 16'($urandom); max_steps = 16'($urandom);
         if (reset_at == fired) begin
            reset = 1'b1;
            start = 1'b0;
            step();
            reset = 1'b0;
            chk("rst_ena", 32'(ena), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_steps", 32'(steps), 32'd0);
            chk("rst_deadlock", 32'(deadlock), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            return;
         end
         step();
         start = 1'b0;
         st = st + 16'd1;
         if (mx != 16'd0 && st == mx) begin
            exp_end_q.push_back(end_t'{steps: st, dl: 1'b0});
            break;
         end
      end
      chk("busy_done", 32'(busy), 32'd0);
      hold = 1'b0;
      excited = N'($urandom);
      step();
      step();
      chk("ena_queue_drained", 32'(exp_ena_q.size()), 32'd0);
      chk("end_queue_drained", 32'(exp_end_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected run completion");
      $fatal(1);
   end

   initial begin
      bit          rm;
      logic [15:0] rs, rmx;
      int          rdl;
      reset = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; max_steps = '0;
      hold = 1'b0; excited = '0;
      step();
      step();
      reset = 1'b0;
      chk("reset_ena", 32'(ena), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_deadlock", 32'(deadlock), 32'd0);
      chk("reset_steps", 32'(steps), 32'd0);

      // reset outranks start in the same cycle
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      chk("reset_over_start", 32'(busy), 32'd0);
      step();
      chk("reset_over_start_idle", 32'(busy), 32'd0);

      run(1'b0, 16'd1, 16'd6, 1'b1, 4'b1111, -1, -1, -1, 1'b0);
      run(1'b0, 16'd1, 16'd3, 1'b1, 4'b1010, -1, -1, -1, 1'b0);
      run(1'b0, 16'd1, 16'd5, 1'b1, 4'b0000, -1, -1, -1, 1'b0);
      run(1'b1, 16'd0, 16'd8, 1'b1, 4'b0110, -1, -1, -1, 1'b0);
      run(1'b1, 16'd1, 16'd8, 1'b1, 4'b0110, -1, -1, -1, 1'b0);
      run(1'b0, 16'd1, 16'd6, 1'b0, 4'b0000, -1, 2, -1, 1'b0);
      run(1'b1, 16'h1234, 16'd6, 1'b0, 4'b0000, -1, -1, 2, 1'b0);
      run(1'b0, 16'd1, 16'd4, 1'b1, 4'b1111, -1, -1, -1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         rm  = 1'($urandom);
         rs  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         rmx = 16'($urandom_range(0, 10));
         rdl = (rmx == 16'd0 || $urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
         run(rm, rs, rmx, 1'b0, 4'b0000, rdl, -1, -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ena_scheduler.md
ENA_SCHEDULER -- requirements
Module: ena_scheduler

Interface
REQ-001 Parameter: ENA_BITS, 8, number of enable bits (circuit inputs + gate instances); SHALL be >= 2.
REQ-002 Parameter: LFSR_W, 16, width of the pseudo-random selection register.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle pulse; begins a run.
REQ-006 Port: mode  input  1  0 = round-robin selection, 1 = pseudo-random selection; sampled on accepted start.
REQ-007 Port: seed  input  LFSR_W  LFSR initial value; sampled on accepted start.
REQ-008 Port: max_steps  input  16  firing budget; 0 = unlimited; sampled on accepted start.
REQ-009 Port: hold  input  1  pauses selection while high.
REQ-010 Port: excited  input  ENA_BITS  bit i high = signal i's next value differs from its current value.
REQ-011 Port: ena  output  ENA_BITS  registered one-hot (or zero) enable vector to the circuit model.
REQ-012 Port: busy  output  1  high in SELECT or FIRE.
REQ-013 Port: done  output  1  single-cycle pulse on entry to DONE.
REQ-014 Port: deadlock  output  1  sticky; high if the run ended with excited == 0.
REQ-015 Port: steps  output  16  firings in current/last run; wraps at 2^16.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, FIRE, DONE.
REQ-017 IDLE: ena = 0; start -> SELECT; on that edge load mode, max_steps, LFSR (seed, or 1 if seed == 0), clear steps and deadlock, set round-robin pointer to 0.
REQ-018 start SHALL be ignored outside IDLE and DONE; start in DONE behaves as in IDLE.
REQ-019 SELECT with hold = 1: remain in SELECT, ena = 0, no LFSR advance.
REQ-020 SELECT with hold = 0 and excited == 0: -> DONE, deadlock <= 1.
REQ-021 SELECT with hold = 0 and excited != 0: choose index k, register ena <= one-hot(k), -> FIRE.
REQ-022 Choice of k: first set bit of excited scanning upward from base index b with wrap-around modulo ENA_BITS.
REQ-023 b SHALL be the pointer in mode 0; in mode 1, LFSR value mod ENA_BITS.
REQ-024 Mode 0: pointer <= (k+1) mod ENA_BITS on every choice.
REQ-025 Mode 1: LFSR (Galois, maximal-length polynomial) SHALL advance once per choice.
REQ-026 FIRE: ena held one-hot for exactly one cycle; steps <= steps+1; then ena <= 0.
REQ-027 FIRE exit: if max_steps != 0 and incremented steps == max_steps -> DONE (deadlock = 0); else -> SELECT.
REQ-028 ena SHALL never have more than one bit set and SHALL only set a bit that was high in excited during the preceding SELECT cycle.
REQ-029 Minimum firing period SHALL be 2 cycles (SELECT, FIRE); excited is sampled only in SELECT, while ena = 0.
REQ-030 DONE: ena = 0; steps and deadlock hold until next accepted start.

Reset
REQ-031 reset SHALL force IDLE, ena = 0, busy = 0, done = 0, deadlock = 0, steps = 0, pointer = 0, LFSR = 1, from any state including mid-FIRE.
REQ-032 reset has priority over start in the same cycle.

Structure
REQ-033 Shared package sched_pkg SHALL hold the state enum, the LFSR tap constants per LFSR_W, and the steps width constant.
REQ-034 One sub-module rr_pick SHALL implement the wrap-around first-one finder (inputs request vector and base index; outputs index and valid).

Verification
REQ-035 ENA_BITS=4, mode 0, excited held 4'b1111, max_steps=6 -> ena sequence 0001,0010,0100,1000,0001,0010 on alternate cycles; done pulse; steps=6; deadlock=0.
REQ-036 Mode 0, excited = 4'b1010 constant, max_steps=3 -> ena 0010,1000,0010; pointer wraps correctly.
REQ-037 excited = 0 at first SELECT -> DONE within 1 cycle, deadlock=1, steps=0, ena never nonzero.
REQ-038 Mode 1, seed 0 vs seed 1 with identical excited -> identical ena sequences; every ena bit is within excited.
REQ-039 hold high for 5 cycles mid-run -> ena stays 0, steps unchanged, run resumes with same next choice.
REQ-040 reset asserted in FIRE cycle -> next cycle ena=0, busy=0, steps=0; subsequent start runs normally.
